frame_sync_ctrl: RTL and testbench

Controller that acquires, verifies and tracks a programmable sync word in a serial bit stream, built around an internal shift-register pattern matcher.
- Runs a hunt/verify/locked state machine with a flywheel bit counter.
- Once locked, gates payload bits to downstream logic and flags missing sync words.
- Sits between the serial receiver front end and the payload deserialiser.

---
 rtl/frame_sync_ctrl.sv | 176 +++++++++++++++++
 tb/tb_frame_sync_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_ctrl.sv
// Sync word hunt/verify/lock controller with flywheel framing.
// Gates payload bits and flags missed sync words once locked.
module frame_sync_ctrl #(
  parameter int PAT_W       = 4,
  parameter int PAYLOAD_LEN = 8,
  parameter int LOCK_CNT    = 2,
  parameter int LOSS_CNT    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PAT_W-1:0] pattern,
  input  logic             bit_valid,
  input  logic             serial_in,
  output logic             locked,
  output logic             sync_pulse,
  output logic             sync_err,
  output logic             payload_valid,
  output logic             payload_bit,
  output logic [1:0]       state
);

  localparam int P  = PAYLOAD_LEN + PAT_W;
  localparam int BW = $clog2(P + 1);
  localparam int FW = $clog2(PAT_W + 1);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [BW-1:0] P_C    = BW'(P);
  localparam logic [BW-1:0] PL_C   = BW'(PAYLOAD_LEN);
  localparam logic [FW-1:0] FULL   = FW'(PAT_W);
  localparam logic [FW-1:0] FULL_1 = FW'(PAT_W - 1);
  localparam logic [HW-1:0] HMAX   = HW'(LOCK_CNT);
  localparam logic [HW-1:0] HLAST  = HW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MMAX   = MW'(LOSS_CNT);
  localparam logic [MW-1:0] MLAST  = MW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_e;

  state_e           st_q, st_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [BW-1:0]    cnt_q, cnt_d;
  logic [HW-1:0]    hit_q, hit_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic             lock_q, lock_d;
  logic             sp_q, sp_d;
  logic             se_q, se_d;
  logic             pv_q, pv_d;
  logic             pb_q, pb_d;

  logic [PAT_W-1:0] sr_nxt;
  logic [BW-1:0]    cnt_nxt;
  logic             match;
  logic             at_end;

  always_comb begin
    sr_nxt  = {sr_q[PAT_W-2:0], serial_in};
    match   = (sr_nxt == pattern) && (fill_q >= FULL_1);
    cnt_nxt = cnt_q + BW'(1);
    at_end  = (cnt_nxt == P_C);

    st_d   = st_q;
    sr_d   = sr_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    hit_d  = hit_q;
    miss_d = miss_q;
    sp_d   = 1'b0;
    se_d   = 1'b0;
    pv_d   = 1'b0;
    pb_d   = 1'b0;

    if (!en) begin
      st_d   = HUNT;
      sr_d   = '0;
      fill_d = '0;
      cnt_d  = '0;
      hit_d  = '0;
      miss_d = '0;
    end else if (bit_valid) begin
      sr_d = sr_nxt;
      if (fill_q != FULL) fill_d = fill_q + FW'(1);
      unique case (st_q)
        HUNT: begin
          if (match) begin
            st_d  = VERIFY;
            cnt_d = '0;
            hit_d = HW'(1);
          end
        end
        VERIFY: begin
          cnt_d = cnt_nxt;
          if (at_end) begin
            cnt_d = '0;
            if (match) begin
              if (hit_q != HMAX) hit_d = hit_q + HW'(1);
              if (hit_q >= HLAST) begin
                st_d   = LOCKED;
                miss_d = '0;
              end
            end else begin
              st_d  = HUNT;
              hit_d = '0;
            end
          end
        end
        LOCKED: begin
          cnt_d = cnt_nxt;
          if (cnt_nxt <= PL_C) begin
            pv_d = 1'b1;
            pb_d = serial_in;
          end
          // flywheel: frame boundary is kept even when sync is missed
          if (at_end) begin
            cnt_d = '0;
            if (match) begin
              sp_d   = 1'b1;
              miss_d = '0;
            end else begin
              se_d = 1'b1;
              if (miss_q != MMAX) miss_d = miss_q + MW'(1);
              if (miss_q >= MLAST) begin
                st_d  = HUNT;
                hit_d = '0;
              end
            end
          end
        end
        default: st_d = HUNT;
      endcase
    end

    lock_d = (st_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= HUNT;
      sr_q   <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      hit_q  <= '0;
      miss_q <= '0;
      lock_q <= 1'b0;
      sp_q   <= 1'b0;
      se_q   <= 1'b0;
      pv_q   <= 1'b0;
      pb_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      sr_q   <= sr_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      miss_q <= miss_d;
      lock_q <= lock_d;
      sp_q   <= sp_d;
      se_q   <= se_d;
      pv_q   <= pv_d;
      pb_q   <= pb_d;
    end
  end

  assign state         = st_q;
  assign locked        = lock_q;
  assign sync_pulse    = sp_q;
  assign sync_err      = se_q;
  assign payload_valid = pv_q;
  assign payload_bit   = pb_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Randomized bench for frame_sync_ctrl against a frame-level model.
// Directed scenarios pin the model with literal expectations.
module tb_frame_sync_ctrl;

  localparam int PW = 4;
  localparam int PL = 8;
  localparam int LK = 2;
  localparam int LS = 2;
  localparam int P  = PL + PW;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          bit_valid;
  logic          serial_in;
  logic [PW-1:0] pattern;
  logic          locked;
  logic          sync_pulse;
  logic          sync_err;
  logic          payload_valid;
  logic          payload_bit;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;
  int stall_pct = 0;
  bit chk_on = 0;

  frame_sync_ctrl #(
    .PAT_W(PW), .PAYLOAD_LEN(PL), .LOCK_CNT(LK), .LOSS_CNT(LS)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pattern(pattern),
    .bit_valid(bit_valid), .serial_in(serial_in),
    .locked(locked), .sync_pulse(sync_pulse), .sync_err(sync_err),
    .payload_valid(payload_valid), .payload_bit(payload_bit),
    .state(state)
  );

  always #5 clk = ~clk;

  // model: mode 0 hunt, 1 verify, 2 locked; pos = bits into frame
  int   mode, pos, hits, misses;
  bit   hist[$];
  logic [1:0] n_state, e_state;
  logic n_lock, n_sp, n_se, n_pv, n_pb;
  logic e_lock, e_sp, e_se, e_pv, e_pb;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit win_match();
    logic [PW-1:0] w;
    if (hist.size() < PW) return 1'b0;
    for (int i = 0; i < PW; i++) w[PW-1-i] = hist[i];
    return w == pattern;
  endfunction

  task automatic model_clear();
    hist.delete();
    mode = 0; pos = 0; hits = 0; misses = 0;
    n_state = 2'b00; n_lock = 0;
    n_sp = 0; n_se = 0; n_pv = 0; n_pb = 0;
  endtask

  task automatic model_apply();
    e_state = n_state; e_lock = n_lock;
    e_sp = n_sp; e_se = n_se; e_pv = n_pv; e_pb = n_pb;
  endtask

  task automatic model_step(input logic e, input logic v, input logic s);
    bit m;
    if (!reset || !e) begin
      model_clear();
      return;
    end
    n_sp = 0; n_se = 0; n_pv = 0; n_pb = 0;
    if (!v) return;
    hist.push_back(s);
    if (hist.size() > PW) void'(hist.pop_front());
    m = win_match();
    if (mode == 0) begin
      if (m) begin mode = 1; pos = 0; hits = 1; end
    end else if (mode == 1) begin
      pos++;
      if (pos == P) begin
        pos = 0;
        if (m) begin
          hits++;
          if (hits >= LK) begin mode = 2; misses = 0; end
        end else begin
          mode = 0; hits = 0;
        end
      end
    end else begin
      pos++;
      if (pos <= PL) begin n_pv = 1; n_pb = s; end
      if (pos == P) begin
        pos = 0;
        if (m) begin
          n_sp = 1; misses = 0;
        end else begin
          n_se = 1; misses++;
          if (misses >= LS) begin mode = 0; hits = 0; end
        end
      end
    end
    n_state = (mode == 2) ? 2'b10 : (mode == 1) ? 2'b01 : 2'b00;
    n_lock  = (mode == 2);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("state", 32'(state), 32'(e_state));
      check("locked", 32'(locked), 32'(e_lock));
      check("sync_pulse", 32'(sync_pulse), 32'(e_sp));
      check("sync_err", 32'(sync_err), 32'(e_se));
      check("payload_valid", 32'(payload_valid), 32'(e_pv));
      if (e_pv) check("payload_bit", 32'(payload_bit), 32'(e_pb));
    end
  end

  task automatic cycle(input logic e, input logic v, input logic s);
    en = e; bit_valid = v; serial_in = s;
    model_step(e, v, s);
    @(posedge clk); #1;
    model_apply();
  endtask

  task automatic sendb(input logic b);
    while ($urandom_range(99) < 32'(stall_pct))
      cycle(1'b1, 1'b0, 1'($urandom));
    cycle(1'b1, 1'b1, b);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) sendb(w[i]);
  endtask

  task automatic send_frame(input logic [7:0] pl, input logic [3:0] sy,
                            output logic [7:0] got, output int npv,
                            output int nsp, output int nse);
    logic [11:0] w;
    w = {pl, sy};
    got = '0; npv = 0; nsp = 0; nse = 0;
    for (int i = 11; i >= 0; i--) begin
      sendb(w[i]);
      if (payload_valid) begin
        got = {got[6:0], payload_bit};
        npv++;
      end
      nsp += int'(sync_pulse);
      nse += int'(sync_err);
    end
  endtask

  task automatic acquire();
    cycle(1'b0, 1'b1, 1'b0);
    send_bits(32'(pattern), PW);
    send_bits(32'($urandom), PL);
    send_bits(32'(pattern), PW);
  endtask

  logic [7:0] got;
  int npv, nsp, nse;

  initial begin
    reset = 1'b0; en = 1'b0; bit_valid = 1'b0; serial_in = 1'b0;
    pattern = 4'b0110;
    model_clear(); model_apply();
    @(posedge clk); #1;
    chk_on = 1;

    // 1: reset held, random bits
    en = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'($urandom));
    check("rst_state", 32'(state), 32'h0);
    check("rst_outs", 32'({locked, sync_pulse, sync_err, payload_valid,
                            payload_bit}), 32'h0);
    reset = 1'b1;
    send_bits(32'b011, 3);
    check("fill_nomatch", 32'(state), 32'h0);

    // 2: acquisition
    sendb(1'b0);
    check("hunt_to_verify", 32'(state), 32'h1);
    check("model_verify", 32'(e_state), 32'h1);
    send_bits(32'h5A, PL);
    send_bits(32'b0110, PW);
    check("verify_to_lock", 32'(state), 32'h2);
    check("lock_no_pulse", 32'({locked, sync_pulse}), 32'h2);
    send_frame(8'b10110011, 4'b0110, got, npv, nsp, nse);
    check("payload_bits", 32'(got), 32'hB3);
    check("payload_count", 32'(npv), 32'd8);
    check("sync_pulse_last", 32'(sync_pulse), 32'h1);
    check("sync_pulse_once", 32'(nsp), 32'd1);

    // 3: verify failure
    cycle(1'b0, 1'b1, 1'b0);
    send_bits(32'b0110, PW);
    send_bits(32'h3C, PL);
    send_bits(32'b0111, PW);
    check("verify_fail", 32'({locked, state}), 32'h0);

    // 4: flywheel and loss
    acquire();
    check("relock", 32'(locked), 32'h1);
    send_frame(8'h96, 4'b0100, got, npv, nse, nse);
    check("err1_pulse", 32'(sync_err), 32'h1);
    check("err1_locked", 32'(locked), 32'h1);
    check("err1_payload", 32'(npv), 32'd8);
    send_frame(8'h21, 4'b0100, got, npv, nsp, nse);
    check("err2_pulse", 32'(sync_err), 32'h1);
    check("loss_state", 32'({locked, state}), 32'h0);
    check("model_loss", 32'(e_state), 32'h0);
    acquire();
    send_frame(8'hF0, 4'b0100, got, npv, nsp, nse);
    send_frame(8'h0F, 4'b0110, got, npv, nsp, nse);
    send_frame(8'hC3, 4'b0100, got, npv, nsp, nse);
    check("miss_reset_hold", 32'({locked, state}), 32'h6);

    // 5: stalls on the test 2 stream
    stall_pct = 40;
    acquire();
    send_frame(8'b10110011, 4'b0110, got, npv, nsp, nse);
    check("stall_payload", 32'(got), 32'hB3);
    check("stall_sync", 32'(nsp), 32'd1);
    stall_pct = 0;

    // 6: mid-frame en clear, then async reset
    send_bits(32'h15, 5);
    cycle(1'b0, 1'b1, 1'b1);
    check("en_clear", 32'({locked, state, payload_valid}), 32'h0);
    acquire();
    check("reacq_en", 32'(locked), 32'h1);
    send_bits(32'h0B, 5);
    #2 reset = 1'b0;
    #1;
    check("async_rst", 32'({locked, state, payload_valid}), 32'h0);
    model_clear(); model_apply();
    @(posedge clk); #1;
    cycle(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    acquire();
    check("reacq_rst", 32'(state), 32'h2);

    // randomized soak
    for (int f = 0; f < 300; f++) begin
      int r;
      r = int'($urandom_range(99));
      stall_pct = int'($urandom_range(30));
      if (r < 3) begin
        cycle(1'b0, 1'b1, 1'($urandom));
        if ($urandom_range(1) == 1) pattern = 4'($urandom);
        cycle(1'b0, 1'b0, 1'b0);
      end else if (r < 8) begin
        sendb(1'($urandom));
      end else if (r < 10) begin
        acquire();
      end else begin
        send_frame(8'($urandom),
                   ($urandom_range(99) < 75) ? pattern : 4'($urandom),
                   got, npv, nsp, nse);
      end
    end

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
